// File: rtl/online_pms_seq.sv
// Radix-2 online (most-significant-digit-first) signed-digit multiplier with online delay 2.
// Takes one {x,y} digit pair per step and emits one product digit per step over valid/ready.
//
// state | meaning
// IDLE  | waiting for start, in_ready low
// INIT  | steps k=1..2, residual fill only, no output digit
// RUN   | steps k=3..N, input digits consumed, one product digit per step
// FLUSH | steps k=N+1..N+2, zero inputs, last two product digits
module online_pms_seq #(
   parameter int N = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] x_dig,
   input  logic [1:0] y_dig,
   output logic [1:0] z_dig,
   output logic       z_valid,
   input  logic       z_ready,
   output logic       z_last,
   output logic       busy
);

   localparam int DELTA = 2;
   localparam int F     = N + 2;
   localparam int WL    = N + 5;
   localparam int KW    = $clog2(N + 4);

   localparam logic signed [WL-1:0] ONE  = {{(WL-1){1'b0}}, 1'b1} << F;
   localparam logic signed [WL-1:0] HALF = {{(WL-1){1'b0}}, 1'b1} << (F - 1);

   typedef enum logic [1:0] {IDLE, INIT, RUN, FLUSH} state_t;

   state_t               state, state_nxt;
   logic signed [WL-1:0] xacc, yacc, w;
   logic [KW-1:0]        k;

   logic                 out_free, use_in, step, emit;
   logic [1:0]           x_eff, y_eff;
   logic [KW-1:0]        sh;
   logic signed [WL-1:0] unit, xacc_nxt, yacc_nxt, h, v, w_sel, w_nxt;
   logic [1:0]           z_sel;

   // Multiply a WL-bit value by a signed digit {pos,neg}; 00 and 11 both mean zero.
   function automatic logic signed [WL-1:0] sd_mul(input logic [1:0] d,
                                                   input logic signed [WL-1:0] a);
      case (d)
         2'b10:   sd_mul = a;
         2'b01:   sd_mul = -a;
         default: sd_mul = '0;
      endcase
   endfunction

   assign out_free = !z_valid || z_ready;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      use_in    = (state == INIT) || (state == RUN);
      in_ready  = use_in && out_free;
      step      = (in_ready && in_valid) || ((state == FLUSH) && out_free);
      emit      = step && ((state == RUN) || (state == FLUSH));

      case (state)
         IDLE:    if (start) state_nxt = INIT;
         INIT:    if (step && (k == KW'(DELTA))) state_nxt = RUN;
         RUN:     if (step && (k == KW'(N))) state_nxt = FLUSH;
         FLUSH:   if (step && (k == KW'(N + DELTA))) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Residual recurrence: W is kept scaled by 2^(k-2), so each new partial product enters at 2^-2.
   always_comb begin
      x_eff    = use_in ? x_dig : 2'b00;
      y_eff    = use_in ? y_dig : 2'b00;
      sh       = KW'(F) - k;
      unit     = {{(WL-1){1'b0}}, 1'b1} << sh;
      yacc_nxt = yacc + sd_mul(y_eff, unit);
      xacc_nxt = xacc + sd_mul(x_eff, unit);
      h        = (sd_mul(y_eff, xacc) + sd_mul(x_eff, yacc_nxt)) >>> 2;
      v        = (w <<< 1) + h;
      z_sel    = 2'b00;
      w_sel    = v;
      if (v >= HALF) begin
         z_sel = 2'b10;
         w_sel = v - ONE;
      end else if (v < -HALF) begin
         z_sel = 2'b01;
         w_sel = v + ONE;
      end
      w_nxt = emit ? w_sel : v;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xacc    <= '0;
         yacc    <= '0;
         w       <= '0;
         k       <= '0;
         z_dig   <= 2'b00;
         z_valid <= 1'b0;
         z_last  <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            xacc <= '0;
            yacc <= '0;
            w    <= '0;
            k    <= KW'(1);
         end else if (step) begin
            xacc <= xacc_nxt;
            yacc <= yacc_nxt;
            w    <= w_nxt;
            k    <= k + KW'(1);
         end

         if (emit) begin
            z_dig   <= z_sel;
            z_valid <= 1'b1;
            z_last  <= (k == KW'(N + DELTA));
         end else if (z_ready) begin
            z_valid <= 1'b0;
            z_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_online_pms_seq.sv
// Bench for online_pms_seq: N=4 and N=8 instances, scoreboard of expected products and digits,
// value checked against plain integer X*Y.
module tb_online_pms_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      start, in_valid, in_ready, z_valid, z_ready, z_last, busy;
   logic [1:0][1:0] x_dig, y_dig, z_dig;

   online_pms_seq #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .x_dig(x_dig[0]), .y_dig(y_dig[0]), .z_dig(z_dig[0]), .z_valid(z_valid[0]),
      .z_ready(z_ready[0]), .z_last(z_last[0]), .busy(busy[0]));

   online_pms_seq #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .x_dig(x_dig[1]), .y_dig(y_dig[1]), .z_dig(z_dig[1]), .z_valid(z_valid[1]),
      .z_ready(z_ready[1]), .z_last(z_last[1]), .busy(busy[1]));

   typedef struct packed {
      int     dut;
      int     n;
      longint prod;       // X*Y scaled by 2^(2n)
      bit     check_dig;
   } exp_t;

   exp_t   sbq[$];
   int     dig_q[$];
   int     checks = 0;
   int     failures = 0;
   bit     rand_rdy = 1'b0;
   int     xv[8], yv[8], zexp[8];
   int     got_cnt[2];
   longint got_acc[2];
   bit     held[2];
   logic [1:0] held_dig[2];
   logic   held_last[2];

   task automatic chk(input string name, input int d, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   function automatic logic [1:0] enc(input int val);
      if (val > 0) return 2'b10;
      if (val < 0) return 2'b01;
      return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
   endfunction

   initial begin
      z_ready = 2'b11;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++)
            z_ready[d] = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor: handshakes are decided at the falling edge and complete at the next rising edge.
   always @(negedge clk) begin : mon
      int     zv;
      longint diff;
      exp_t   e;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            got_cnt[d] = 0;
            got_acc[d] = 0;
            held[d]    = 1'b0;
         end else begin
            if (held[d]) begin
               chk("stall_z_valid", d, z_valid[d], 1);
               chk("stall_z_dig", d, z_dig[d], held_dig[d]);
               chk("stall_z_last", d, z_last[d], held_last[d]);
            end
            held[d] = z_valid[d] && !z_ready[d];
            if (held[d]) begin
               held_dig[d]  = z_dig[d];
               held_last[d] = z_last[d];
               chk("stall_in_ready", d, in_ready[d], 0);
            end
            if (z_valid[d] && z_ready[d]) begin
               chk("z_dig_legal", d, z_dig[d] == 2'b11, 0);
               zv = (z_dig[d] == 2'b10) ? 1 : (z_dig[d] == 2'b01) ? -1 : 0;
               if (sbq.size() == 0 || sbq[0].dut != d) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_digit dut%0d: got digit %0d expected none", d, zv);
               end else begin
                  e = sbq[0];
                  got_cnt[d]++;
                  got_acc[d] += longint'(zv) * (longint'(1) << (e.n - got_cnt[d]));
                  if (e.check_dig && dig_q.size() != 0)
                     chk("z_digit", d, zv, dig_q.pop_front());
                  chk("z_last", d, z_last[d], got_cnt[d] == e.n);
                  if (got_cnt[d] == e.n) begin
                     diff = got_acc[d] * (longint'(1) << e.n) - e.prod;
                     if (diff < 0) diff = -diff;
                     checks++;
                     if (diff > (longint'(1) << e.n)) begin
                        failures++;
                        $display("FAIL product dut%0d: got Z*2^2N=%0d expected X*Y*2^2N=%0d",
                                 d, got_acc[d] * (longint'(1) << e.n), e.prod);
                     end
                     void'(sbq.pop_front());
                     got_cnt[d] = 0;
                     got_acc[d] = 0;
                  end
               end
            end
         end
      end
   end

   task automatic run_op(input int d, input int n, input bit chk_dig,
                         input int start_at, input int abort_at);
      longint xi = 0;
      longint yi = 0;
      int     tmo;
      exp_t   e;
      for (int i = 0; i < n; i++) begin
         xi += longint'(xv[i]) * (longint'(1) << (n - 1 - i));
         yi += longint'(yv[i]) * (longint'(1) << (n - 1 - i));
      end
      if (abort_at == 0) begin
         e.dut = d;
         e.n = n;
         e.prod = xi * yi;
         e.check_dig = chk_dig;
         sbq.push_back(e);
         if (chk_dig)
            for (int i = 0; i < n; i++) dig_q.push_back(zexp[i]);
      end
      start[d] = 1'b1;
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid[d] = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid[d] = 1'b1;
         x_dig[d] = enc(xv[i]);
         y_dig[d] = enc(yv[i]);
         if (i == start_at) start[d] = 1'b1;
         tmo = 0;
         do begin
            @(negedge clk);
            tmo++;
         end while (!in_ready[d] && tmo < 100);
         if (!in_ready[d]) begin
            failures++;
            $display("FAIL in_ready_timeout dut%0d: digit %0d not accepted in %0d cycles", d, i, tmo);
            finish_run();
         end
         @(posedge clk);
         #1;
         start[d] = 1'b0;
         if (abort_at == i + 1) begin
            in_valid[d] = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_busy", d, busy[d], 0);
            chk("rst_z_valid", d, z_valid[d], 0);
            chk("rst_in_ready", d, in_ready[d], 0);
            chk("rst_z_dig", d, z_dig[d], 0);
            chk("rst_z_last", d, z_last[d], 0);
            @(posedge clk);
            #1;
            return;
         end
      end
      in_valid[d] = 1'b0;
      tmo = 0;
      while (sbq.size() != 0 && tmo < 400) begin
         @(negedge clk);
         tmo++;
      end
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout dut%0d: %0d results outstanding", d, sbq.size());
         finish_run();
      end
      chk("busy_after_op", d, busy[d], 0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_vec();
      for (int i = 0; i < 8; i++) begin
         xv[i] = int'($urandom_range(0, 2)) - 1;
         yv[i] = int'($urandom_range(0, 2)) - 1;
      end
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   initial begin
      rst = 1'b1;
      start = '0;
      in_valid = '0;
      x_dig = '0;
      y_dig = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_busy", d, busy[d], 0);
         chk("reset_z_valid", d, z_valid[d], 0);
         chk("reset_in_ready", d, in_ready[d], 0);
         chk("reset_z_dig", d, z_dig[d], 0);
         chk("reset_z_last", d, z_last[d], 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // in_valid in IDLE must be ignored
      in_valid[0] = 1'b1;
      x_dig[0] = 2'b10;
      @(negedge clk);
      chk("idle_in_ready", 0, in_ready[0], 0);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("idle_busy", 0, busy[0], 0);
      @(posedge clk);
      #1;

      // 1/2 * 1/2 = 1/4
      xv = '{1, 0, 0, 0, 0, 0, 0, 0};
      yv = '{1, 0, 0, 0, 0, 0, 0, 0};
      zexp = '{1, -1, 0, 0, 0, 0, 0, 0};
      run_op(0, 4, 1'b1, -1, 0);

      // -1/2 * 1/2 = -1/4, checked by value
      xv = '{-1, 0, 0, 0, 0, 0, 0, 0};
      run_op(0, 4, 1'b0, -1, 0);

      xv = '{0, 0, 0, 0, 0, 0, 0, 0};
      yv = '{0, 0, 0, 0, 0, 0, 0, 0};
      zexp = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_op(0, 4, 1'b1, -1, 0);

      // rst wins over start in the same cycle
      rst = 1'b1;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start[0] = 1'b0;
      @(negedge clk);
      chk("rst_over_start", 0, busy[0], 0);
      @(posedge clk);
      #1;

      rand_rdy = 1'b1;
      for (int t = 0; t < 8; t++) begin
         rand_vec();
         run_op(0, 4, 1'b0, -1, 0);
      end

      // largest magnitudes
      xv = '{1, 1, 1, 1, 1, 1, 1, 1};
      yv = '{1, 1, 1, 1, 1, 1, 1, 1};
      run_op(1, 8, 1'b0, -1, 0);
      yv = '{-1, -1, -1, -1, -1, -1, -1, -1};
      run_op(1, 8, 1'b0, -1, 0);

      for (int t = 0; t < 30; t++) begin
         rand_vec();
         run_op(1, 8, 1'b0, (t % 5 == 0) ? int'($urandom_range(2, 7)) : -1, 0);
      end

      // abort after three accepted digits, then a clean operation
      rand_vec();
      run_op(1, 8, 1'b0, -1, 3);
      rand_vec();
      run_op(1, 8, 1'b0, -1, 0);
      rand_vec();
      run_op(0, 4, 1'b0, -1, 3);
      rand_vec();
      run_op(0, 4, 1'b0, 2, 0);

      finish_run();
   end

endmodule
